// File: rtl/mac_result_writer.sv
// mac_result_writer
//   Sits at the output end of the MAC pipeline. It buffers the accumulated row
//   sums in a result FIFO and writes each one to memory as a single 64-bit write.
//   Writes go to consecutive 8-byte addresses starting at a programmed base.
//   When the end of the stream is signalled, it drains the FIFO and then pulses
//   done. The result count stays readable afterwards.
//
// Ports
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   start, base_addr  start a run (IDLE only); base is forced to 8-byte alignment
//   push_in, v_in     result stream from the MAC (push_out / v_out)
//   eof_in            MAC has seen its last input; trailing results still arrive
//   stall_out         registered backpressure to the MAC
//   mem_req/addr/data one-cycle write request with address and data
//   mem_stall         memory busy; suppresses the request in the following cycle
//   busy, done        RUN/DRAIN indicator, one-cycle completion pulse
//   result_count      writes issued in the current or last run
//   overflow          sticky: a result arrived while the FIFO was full
//   o_dbg_state       current FSM state (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE)
//
// Handshakes: push_in is a pure valid with no ready. stall_out only asks the
// MAC to stop, and STALL_MARGIN entries stay free for results already in
// flight. A push into a full FIFO is dropped and flagged. A write is issued
// in cycle t+1 only if in cycle t the FSM was in RUN/DRAIN, the FIFO held data
// and mem_stall was low. mem_req needs no acknowledge.

module mac_result_writer #(
  parameter int FIFO_DEPTH      = 32,
  parameter int LOG2_FIFO_DEPTH = 5,
  parameter int STALL_MARGIN    = 8,
  parameter int ADDR_WIDTH      = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  push_in,
  input  logic [63:0]           v_in,
  input  logic                  eof_in,
  output logic                  stall_out,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]           mem_data,
  input  logic                  mem_stall,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           result_count,
  output logic                  overflow,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Quiet cycles required in DRAIN; covers the MAC pipeline latency after eof.
  localparam int DRAIN_QUIET = 16;
  localparam logic [LOG2_FIFO_DEPTH:0] FULL_LEVEL  = (LOG2_FIFO_DEPTH+1)'(FIFO_DEPTH);
  localparam logic [LOG2_FIFO_DEPTH:0] STALL_LEVEL = (LOG2_FIFO_DEPTH+1)'(FIFO_DEPTH - STALL_MARGIN);
  localparam logic [4:0]               QUIET_LAST  = 5'(DRAIN_QUIET - 1);

  state_t                     r_state;
  state_t                     w_next_state;
  logic [63:0]                r_fifo [FIFO_DEPTH];
  logic [LOG2_FIFO_DEPTH-1:0] r_wr_ptr;
  logic [LOG2_FIFO_DEPTH-1:0] r_rd_ptr;
  logic [LOG2_FIFO_DEPTH:0]   r_count;
  logic [LOG2_FIFO_DEPTH:0]   w_count_next;
  logic [4:0]                 r_quiet;
  logic [ADDR_WIDTH-1:0]      r_base;
  logic [ADDR_WIDTH-1:0]      w_offset;
  logic                       r_stall;
  logic                       r_mem_req;
  logic [ADDR_WIDTH-1:0]      r_mem_addr;
  logic [63:0]                r_mem_data;
  logic [31:0]                r_result_count;
  logic                       r_overflow;
  logic                       w_full;
  logic                       w_empty;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_quiet_done;

  assign w_full  = (r_count == FULL_LEVEL);
  assign w_empty = (r_count == '0);
  assign w_push  = push_in && !w_full;
  assign w_pop   = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !w_empty && !mem_stall;

  // Byte offset of the next write; wraps with the address width.
  assign w_offset = ADDR_WIDTH'({r_result_count, 3'b000});

  assign w_quiet_done = (r_state == S_DRAIN) && w_empty && !push_in && (r_quiet == QUIET_LAST);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + 1'b1;
    else if (!w_push && w_pop) w_count_next = r_count - 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start)        w_next_state = S_RUN;
      S_RUN:   if (eof_in)       w_next_state = S_DRAIN;
      S_DRAIN: if (w_quiet_done) w_next_state = S_DONE;
      S_DONE:                    w_next_state = S_IDLE;
      default:                   w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    o_dbg_state = r_state;
    case (r_state)
      S_RUN, S_DRAIN: busy = 1'b1;
      S_DONE:         done = 1'b1;
      default:        ;
    endcase
  end

  // Consecutive cycles in DRAIN with an empty FIFO and no incoming result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quiet <= '0;
    end else if ((r_state != S_DRAIN) || !w_empty || push_in) begin
      r_quiet <= '0;
    end else begin
      r_quiet <= r_quiet + 1'b1;
    end
  end

  // FIFO storage has no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= v_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base         <= '0;
      r_stall        <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_data     <= '0;
      r_result_count <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_overflow <= r_overflow | (push_in & w_full);
      r_stall    <= (w_count_next >= STALL_LEVEL);
      r_mem_req  <= w_pop;
      if ((r_state == S_IDLE) && start) begin
        r_base         <= {base_addr[ADDR_WIDTH-1:3], 3'b000};
        r_result_count <= '0;
      end
      if (w_pop) begin
        r_mem_data     <= r_fifo[r_rd_ptr];
        r_mem_addr     <= r_base + w_offset;
        r_result_count <= r_result_count + 1'b1;
      end
    end
  end

  assign stall_out    = r_stall;
  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign mem_data     = r_mem_data;
  assign result_count = r_result_count;
  assign overflow     = r_overflow;

endmodule

// File: doc/mac_result_writer.md
Name: mac_result_writer

Overview:
- Consumer at the output end of the MAC pipeline: accepts the push_out/v_out stream of accumulated row sums in IEEE format and buffers it in an internal FIFO.
- Drives the MAC's stall_out backpressure input from FIFO occupancy.
- Issues one 64-bit memory write per result to consecutive addresses from a programmed base.
- On an end-of-stream indication it drains the FIFO, then signals done with the result count.

Parameters:
FIFO_DEPTH, 32, result FIFO entries; power of 2.
LOG2_FIFO_DEPTH, 5, log2(FIFO_DEPTH).
STALL_MARGIN, 8, free entries reserved for results already in flight in the MAC when stall_out rises.
ADDR_WIDTH, 48, memory byte-address width.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  reset; asynchronous assert, active-low (0 = reset).
start  input  1  one-cycle pulse; latches base_addr and begins a run; honoured only in IDLE.
base_addr  input  ADDR_WIDTH  byte address of first result; bits [2:0] ignored (treated as 0).
push_in  input  1  result valid from MAC push_out.
v_in  input  64  result value from MAC v_out.
eof_in  input  1  one-cycle pulse: MAC has been sent its final input; remaining results still arrive.
stall_out  output  1  backpressure to MAC stall_out.
mem_req  output  1  one-cycle write request.
mem_addr  output  ADDR_WIDTH  write byte address.
mem_data  output  64  write data.
mem_stall  input  1  memory not accepting; no mem_req is issued in a cycle following a cycle where mem_stall=1.
busy  output  1  state is RUN or DRAIN.
done  output  1  one-cycle pulse at completion.
result_count  output  32  results written in current/last run.
overflow  output  1  sticky; push_in with FIFO full.

Behaviour:
- Reset (rst=0, async): state IDLE; FIFO empty; stall_out=0, mem_req=0, mem_addr=0, mem_data=0, busy=0, done=0, result_count=0, overflow=0. Reset mid-run discards all FIFO contents and pending writes.
- FIFO write: push_in=1 and not full -> v_in written at that edge, regardless of state. Data arriving in IDLE is held until the next run.
- push_in=1 while full -> value dropped and overflow set. overflow clears only on reset.
- Registered stall_out = (occupancy after this edge >= FIFO_DEPTH - STALL_MARGIN).
- Pop condition, evaluated each cycle: state in {RUN, DRAIN}, FIFO not empty, mem_stall=0.
  - On pop, at the next edge: mem_req<=1, mem_data<=head, mem_addr<=base + 8*result_count, result_count<=result_count+1.
  - Otherwise mem_req<=0; mem_addr and mem_data hold.
- Latency: push_in in cycle t -> earliest mem_req in cycle t+2.
- Simultaneous push and pop on a FIFO that is not empty: occupancy unchanged. Pop on an empty FIFO is never performed (no read-through). Pointers wrap modulo FIFO_DEPTH.
- Address arithmetic is modulo 2^ADDR_WIDTH; result_count wraps at 2^32.
- FSM:
  - IDLE: start -> RUN; base latched (low 3 bits zeroed); result_count<=0.
  - RUN: eof_in -> DRAIN. start is ignored.
  - DRAIN: FIFO empty and push_in=0 for DRAIN_QUIET=16 consecutive cycles -> DONE. Any push restarts the quiet counter, which covers MAC pipeline latency.
  - DONE: done=1 for one cycle -> IDLE. result_count holds until the next start.
- eof_in in IDLE, DRAIN or DONE is ignored. A start coinciding with eof_in in IDLE is treated as start only.

Test Plan:
- Reset, start base=0x1000, push 3 values (0x3FF0000000000000, 0x4000000000000000, 0x4008000000000000) on consecutive cycles, mem_stall=0, eof_in after -> mem_req pulses with addr 0x1000/0x1008/0x1010 carrying those values, first one 2 cycles after first push; done pulse after 16 quiet cycles; result_count=3.
- mem_stall=1 held, push 24 results -> stall_out=1 once occupancy reaches 24; release mem_stall -> 24 writes in order, stall_out drops when occupancy <24.
- Push 33 values with mem_stall=1 -> 32 stored, overflow=1 and remains 1 after drain.
- eof_in, then 2 more pushes at DRAIN+5 and DRAIN+10 cycles -> both written; done only after 16 cycles with no push and FIFO empty; count includes them.
- Assert rst low mid-DRAIN with 10 entries queued -> all outputs to reset values immediately (asynchronous); after release, new start with base=0x2007 -> first address 0x2000, no stale data written.
- Push 2 values in IDLE, then start base=0 -> both written to 0x0 and 0x8 after start.
